// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending scoreboard.
// Two prioritised write ports, optional same-cycle forwarding to the reads.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_ready,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic [NREGS-1:0]      busy
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NREGS-1:0]             pend_q, pend_d;

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // a reserve is applied last so a new producer outranks a retiring one.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int r = 0; r < NREGS; r++) begin
            if (we0 && wa0 == AW'(r)) begin
                mem_d[r]  = wd0;
                pend_d[r] = 1'b0;
            end
            if (we1 && wa1 == AW'(r)) begin
                mem_d[r]  = wd1;
                pend_d[r] = 1'b0;
            end
            if (rsv_en && rsv_addr == AW'(r)) begin
                pend_d[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0]  = '0;
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            if (ZERO_REG != 0 && a == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_ready[i]                 = 1'b1;
            end else if (BYPASS != 0 && we1 && wa1 == a) begin
                rd_data[i*DATA_W +: DATA_W] = wd1;
                rd_ready[i]                 = 1'b1;
            end else if (BYPASS != 0 && we0 && wa0 == a) begin
                rd_data[i*DATA_W +: DATA_W] = wd0;
                rd_ready[i]                 = 1'b1;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = mem_q[a];
                rd_ready[i]                 = !pend_q[a];
            end
        end
    end

    assign busy = pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based model.
// Inputs change on the falling edge; outputs are sampled mid-low-phase.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 2;
    localparam int AW = 5;

    logic              clk;
    logic              reset;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_ready;
    logic              we0, we1, rsv_en;
    logic [AW-1:0]     wa0, wa1, rsv_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [NR-1:0]     busy;

    int checks;
    int failures;

    logic [DW-1:0] m_mem [NR];
    bit            m_pend[NR];

    regfile_mp #(
        .DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge, in order of increasing priority.
    task automatic model_commit();
        if (!reset) return;
        if (we0) begin
            m_mem[wa0]  = wd0;
            m_pend[wa0] = 1'b0;
        end
        if (we1) begin
            m_mem[wa1]  = wd1;
            m_pend[wa1] = 1'b0;
        end
        if (rsv_en) m_pend[rsv_addr] = 1'b1;
        m_mem[0]  = '0;
        m_pend[0] = 1'b0;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic exp_rdy(input logic [AW-1:0] a);
        if (a == 0) return 1'b1;
        if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b1;
        return !m_pend[a];
    endfunction

    function automatic logic [NR-1:0] exp_busy();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    // Edge, model update, then move to the next falling edge for new stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr = {5'd5, 5'd5};
        #2;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL preload x5 got=%h want=deadbeef", rd_data[31:0]);
        end
        #1;
        reset = 0;
        #1;
        model_clear();
        checks++;
        if (rd_data[31:0] !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", rd_data[31:0]);
        end
        checks++;
        if (rd_ready !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b want=11", rd_ready);
        end
        checks++;
        if (busy !== '0) begin
            failures++;
            $display("FAIL reset_busy got=%h want=0", busy);
        end
        // Writes and reserves during reset must be ignored.
        @(negedge clk);
        we0 = 1; wa0 = 6; wd0 = 32'h1111;
        rsv_en = 1; rsv_addr = 6;
        tick();
        idle();
        reset = 1;
        rd_addr = {5'd6, 5'd6};
        #2;
        checks++;
        if (rd_data[31:0] !== '0 || busy !== '0) begin
            failures++;
            $display("FAIL reset_ignore data=%h busy=%h want 0/0",
                     rd_data[31:0], busy);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass_write();
        idle();
        we0 = 1; wa0 = 7; wd0 = 32'h12345678;
        rd_addr = {5'd3, 5'd7};
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h12345678 || rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_same got=%h/%b want=12345678/1",
                     rd_data[31:0], rd_ready[0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_stored got=%h want=12345678", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_collision();
        idle();
        we0 = 1; wa0 = 3; wd0 = 32'hAAAA;
        we1 = 1; wa1 = 3; wd1 = 32'h5555;
        rd_addr = {5'd3, 5'd3};
        #2;
        checks++;
        if (rd_data !== {32'h5555, 32'h5555}) begin
            failures++;
            $display("FAIL collide_fwd got=%h want=5555 on both", rd_data);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h5555) begin
            failures++;
            $display("FAIL collide_store got=%h want=5555", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        idle();
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 0;
        rd_addr = {5'd0, 5'd0};
        #2;
        checks++;
        if (rd_data[31:0] !== '0 || rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL zero_same got=%h/%b want=0/1",
                     rd_data[31:0], rd_ready[0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== '0 || rd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_after got=%h/%b busy0=%b want=0/1/0",
                     rd_data[31:0], rd_ready[0], busy[0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1; rsv_addr = 9;
        rd_addr = {5'd0, 5'd9};
        tick();
        idle();
        #2;
        checks++;
        if (busy[9] !== 1'b1 || rd_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL sb_pending busy9=%b rdy=%b want=1/0",
                     busy[9], rd_ready[0]);
        end
        tick();
        tick();
        we0 = 1; wa0 = 9; wd0 = 32'h42;
        #2;
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h42 || busy[9] !== 1'b1) begin
            failures++;
            $display("FAIL sb_release_fwd rdy=%b data=%h busy9=%b want=1/42/1",
                     rd_ready[0], rd_data[31:0], busy[9]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (busy[9] !== 1'b0 || rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h42) begin
            failures++;
            $display("FAIL sb_released busy9=%b rdy=%b data=%h want=0/1/42",
                     busy[9], rd_ready[0], rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_reserve_race();
        idle();
        rsv_en = 1; rsv_addr = 4;
        we1 = 1; wa1 = 4; wd1 = 32'h99;
        rd_addr = {5'd0, 5'd4};
        tick();
        idle();
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h99 || busy[4] !== 1'b1 || rd_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL race data=%h busy4=%b rdy=%b want=99/1/0",
                     rd_data[31:0], busy[4], rd_ready[0]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            we0      = ($urandom_range(0, 1) == 1);
            wa0      = AW'($urandom_range(0, 7));
            wd0      = $urandom;
            we1      = ($urandom_range(0, 2) == 0);
            wa1      = AW'($urandom_range(0, 7));
            wd1      = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wa0 = AW'($urandom_range(0, NR - 1));
            for (int i = 0; i < NP; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
            #2;
            for (int i = 0; i < NP; i++) begin
                logic [AW-1:0] a;
                a = rd_addr[i*AW +: AW];
                checks++;
                if (rd_data[i*DW +: DW] !== exp_data(a) || rd_ready[i] !== exp_rdy(a)) begin
                    failures++;
                    $display("FAIL rand_read n=%0d port=%0d addr=%0d got=%h/%b want=%h/%b",
                             n, i, a, rd_data[i*DW +: DW], rd_ready[i],
                             exp_data(a), exp_rdy(a));
                end
            end
            checks++;
            if (busy !== exp_busy()) begin
                failures++;
                $display("FAIL rand_busy n=%0d got=%h want=%h", n, busy, exp_busy());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 0;
        rd_addr  = '0;
        idle();
        model_clear();
        #12;
        reset = 1;
        test_reset();
        test_bypass_write();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_reserve_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending scoreboard. It sits in the decode/writeback boundary of the core. Decode reads operands and reserves destination registers; one or two writeback sources retire results. Writes of the current cycle can optionally be forwarded to the read ports, so a pipelined core can issue without a separate bypass network.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never pending
- AW (derived, not overridable), $clog2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NRD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_ready  out  NRD  1 = rd_data[i] is architecturally valid (register not pending, or forwarded)
- we0  in  1  write enable, port 0 (low priority)
- wa0  in  AW  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (high priority)
- wa1  in  AW  write address, port 1
- wd1  in  DATA_W  write data, port 1
- rsv_en  in  1  reserve (mark pending) the register at rsv_addr
- rsv_addr  in  AW  register to reserve
- busy  out  NREGS  pending bit per register (registered)

## Operation
- Storage: NREGS × DATA_W flops plus NREGS pending flops.
- Reset (reset=0): all registers become 0 and all pending bits become 0, immediately and asynchronously. Resulting outputs: rd_data all 0, rd_ready all 1, busy all 0.
- Write: on a rising edge with weN=1, mem[waN] ← wdN.
- Write collision: if we0=we1=1 and wa0==wa1, port 1 is stored and port 0 is dropped.
- ZERO_REG=1: writes to address 0 are discarded. Reserves to address 0 are discarded. Reads of address 0 return 0 with rd_ready=1 regardless of bypass.
- Scoreboard update, per register r, on each rising edge:
  - rsv_en=1 and rsv_addr==r → pending[r]←1.
  - Otherwise, (we0 and wa0==r) or (we1 and wa1==r) → pending[r]←0.
  - Otherwise pending[r] holds.
  - Reserve beats a same-cycle write to the same register, because the new producer supersedes the old one. The data write still occurs.
- Read (combinational), per port i, with a = rd_addr[i]:
  - ZERO_REG and a==0 → rd_data=0, rd_ready=1.
  - Else BYPASS=1 and we1 and wa1==a → rd_data=wd1, rd_ready=1.
  - Else BYPASS=1 and we0 and wa0==a → rd_data=wd0, rd_ready=1.
  - Else rd_data=mem[a], rd_ready=!pending[a].
- Forwarding does not consult rsv_en; a same-cycle reserve affects only the next cycle.
- All read ports are fully independent. Any ports may share an address.
- busy = pending vector. busy[0] is always 0 when ZERO_REG=1.

## Timing
- Write-to-read latency:
  - BYPASS=1: 0 cycles (forwarded in the write cycle).
  - BYPASS=0: 1 cycle (visible after the edge).
- Reserve-to-busy: 1 cycle. busy/rd_ready reflect the reserve after the next rising edge.
- Write-to-release: pending clears at the same edge that stores the data.
- rd_data/rd_ready are combinational from rd_addr, we*, wa*, wd* and state. There is no registered read path.
- Reset asserted mid-operation: state clears without waiting for clk. Writes and reserves present while reset=0 are ignored. The first edge after reset deasserts operates normally.

## Test plan
- Reset then read: reset=0 with prior contents 0xDEADBEEF in x5 → rd_data[0]=0, rd_ready=11, busy=0 without a clock edge.
- Write/read with BYPASS=1: we0=1, wa0=7, wd0=0x12345678, rd_addr[0]=7 in the same cycle → rd_data[0]=0x12345678, rd_ready[0]=1. Next cycle, with we0=0, the stored value is still 0x12345678.
- Collision: we0=we1=1, wa0=wa1=3, wd0=0xAAAA, wd1=0x5555 → same-cycle read gives 0x5555, and after the edge x3=0x5555.
- Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF and rsv_en=1, rsv_addr=0 → read of x0 is 0, rd_ready=1, busy[0]=0.
- Scoreboard: rsv_en at x9 in cycle n:
  - Cycle n+1: busy[9]=1, and a read of x9 gives rd_ready=0.
  - Cycle n+3, we0=1, wa0=9, wd0=0x42: same cycle rd_ready=1, data 0x42; busy[9]=0 from n+4.
- Reserve/write race: rsv_en with rsv_addr=4 and we1=1, wa1=4, wd1=0x99 in the same cycle → next cycle x4=0x99, busy[4]=1, rd_ready=0.
